// File: rtl/phy_mem_port_arbiter.sv
// Physical-memory port arbiter: round-robin among I-cache, D-cache and uncachable unit,
// one outstanding transaction, IO-address rejection and WAIT-state response timeout.
module phy_mem_port_arbiter #(
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                       clk,
   input  logic                       rstN,
   input  logic [2:0]                 reqValid,
   input  logic [2:0]                 reqWrite,
   input  logic [2:0][25:0]           reqAddr,
   input  logic [2:0][LINE_WIDTH-1:0] reqWdata,
   output logic [2:0]                 reqAck,
   output logic [2:0]                 rspValid,
   output logic                       rspError,
   output logic [LINE_WIDTH-1:0]      rspData,
   output logic                       memReqValid,
   input  logic                       memReqReady,
   output logic                       memReqWrite,
   output logic [25:0]                memReqAddr,
   output logic [LINE_WIDTH-1:0]      memReqWdata,
   input  logic                       memRspValid,
   input  logic [LINE_WIDTH-1:0]      memRspData
);

   localparam int unsigned NREQ   = 3;
   localparam int unsigned ADDR_W = 26;
   localparam int unsigned IO_BIT = 24;
   localparam int unsigned OFFS_W = $clog2(LINE_WIDTH / 8);
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFFS_W) - ADDR_W'(1));
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [1:0]              rr_ptr_q, rr_ptr_d;
   logic [1:0]              owner_q, owner_d;
   logic                    write_q, write_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
   logic                    rsp_error_q, rsp_error_d;
   logic [LINE_WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic                    mem_req_valid_q, mem_req_valid_d;
   logic                    mem_req_write_q, mem_req_write_d;
   logic [ADDR_W-1:0]       mem_req_addr_q, mem_req_addr_d;
   logic [LINE_WIDTH-1:0]   mem_req_wdata_q, mem_req_wdata_d;

   logic                    gnt_valid;
   logic [1:0]              gnt_idx;
   logic [NREQ-1:0]         gnt_oh;
   logic [2:0]              probe;

   // Round-robin search starting at rr_ptr, wrapping modulo 3
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = 2'd0;
      probe     = 3'd0;
      for (int k = 0; k < NREQ; k++) begin
         probe = 3'(rr_ptr_q) + 3'(k);
         if (probe >= 3'd3) begin
            probe = probe - 3'd3;
         end
         if (!gnt_valid && reqValid[2'(probe)]) begin
            gnt_valid = 1'b1;
            gnt_idx   = 2'(probe);
         end
      end
      gnt_oh = gnt_valid ? (3'b001 << gnt_idx) : 3'b000;
   end

   // Acknowledge is the one combinational output; held off while in reset
   assign reqAck = (state_q == S_IDLE && rstN) ? gnt_oh : 3'b000;

   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      owner_d         = owner_q;
      write_d         = write_q;
      cnt_d           = cnt_q;
      rsp_valid_d     = '0;
      rsp_error_d     = 1'b0;
      rsp_data_d      = '0;
      mem_req_valid_d = mem_req_valid_q;
      mem_req_write_d = mem_req_write_q;
      mem_req_addr_d  = mem_req_addr_q;
      mem_req_wdata_d = mem_req_wdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (gnt_valid) begin
               owner_d = gnt_idx;
               write_d = reqWrite[gnt_idx];
               if (reqAddr[gnt_idx][IO_BIT]) begin
                  // IO space is never forwarded to memory
                  state_d     = S_RESP;
                  rsp_valid_d = gnt_oh;
                  rsp_error_d = 1'b1;
               end else begin
                  state_d         = S_ISSUE;
                  mem_req_valid_d = 1'b1;
                  mem_req_write_d = reqWrite[gnt_idx];
                  mem_req_addr_d  = reqAddr[gnt_idx] & ALIGN_MASK;
                  mem_req_wdata_d = reqWdata[gnt_idx];
               end
            end
         end

         S_ISSUE: begin
            if (memReqReady) begin
               state_d         = S_WAIT;
               cnt_d           = '0;
               mem_req_valid_d = 1'b0;
               mem_req_write_d = 1'b0;
               mem_req_addr_d  = '0;
               mem_req_wdata_d = '0;
            end
         end

         S_WAIT: begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            // A response arriving on the last counted cycle still beats the timeout
            if (memRspValid) begin
               state_d     = S_RESP;
               rsp_valid_d = 3'b001 << owner_q;
               rsp_data_d  = write_q ? '0 : memRspData;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = S_RESP;
               rsp_valid_d = 3'b001 << owner_q;
               rsp_error_d = 1'b1;
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
            unique case (owner_q)
               2'd0:    rr_ptr_d = 2'd1;
               2'd1:    rr_ptr_d = 2'd2;
               default: rr_ptr_d = 2'd0;
            endcase
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q         <= S_IDLE;
         rr_ptr_q        <= 2'd0;
         owner_q         <= 2'd0;
         write_q         <= 1'b0;
         cnt_q           <= '0;
         rsp_valid_q     <= '0;
         rsp_error_q     <= 1'b0;
         rsp_data_q      <= '0;
         mem_req_valid_q <= 1'b0;
         mem_req_write_q <= 1'b0;
         mem_req_addr_q  <= '0;
         mem_req_wdata_q <= '0;
      end else begin
         state_q         <= state_d;
         rr_ptr_q        <= rr_ptr_d;
         owner_q         <= owner_d;
         write_q         <= write_d;
         cnt_q           <= cnt_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_error_q     <= rsp_error_d;
         rsp_data_q      <= rsp_data_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_write_q <= mem_req_write_d;
         mem_req_addr_q  <= mem_req_addr_d;
         mem_req_wdata_q <= mem_req_wdata_d;
      end
   end

   assign rspValid    = rsp_valid_q;
   assign rspError    = rsp_error_q;
   assign rspData     = rsp_data_q;
   assign memReqValid = mem_req_valid_q;
   assign memReqWrite = mem_req_write_q;
   assign memReqAddr  = mem_req_addr_q;
   assign memReqWdata = mem_req_wdata_q;

endmodule

// File: tb/tb_phy_mem_port_arbiter.sv
// Directed bench for phy_mem_port_arbiter with LINE_WIDTH=128, TIMEOUT=8.
module tb_phy_mem_port_arbiter;

   localparam int unsigned LW = 128;
   localparam int unsigned TO = 8;

   logic                clk;
   logic                rstN;
   logic [2:0]          reqValid;
   logic [2:0]          reqWrite;
   logic [2:0][25:0]    reqAddr;
   logic [2:0][LW-1:0]  reqWdata;
   logic [2:0]          reqAck;
   logic [2:0]          rspValid;
   logic                rspError;
   logic [LW-1:0]       rspData;
   logic                memReqValid;
   logic                memReqReady;
   logic                memReqWrite;
   logic [25:0]         memReqAddr;
   logic [LW-1:0]       memReqWdata;
   logic                memRspValid;
   logic [LW-1:0]       memRspData;

   int n_chk;
   int n_err;

   phy_mem_port_arbiter #(.LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rstN        (rstN),
      .reqValid    (reqValid),
      .reqWrite    (reqWrite),
      .reqAddr     (reqAddr),
      .reqWdata    (reqWdata),
      .reqAck      (reqAck),
      .rspValid    (rspValid),
      .rspError    (rspError),
      .rspData     (rspData),
      .memReqValid (memReqValid),
      .memReqReady (memReqReady),
      .memReqWrite (memReqWrite),
      .memReqAddr  (memReqAddr),
      .memReqWdata (memReqWdata),
      .memRspValid (memRspValid),
      .memRspData  (memRspData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".reqAck"},      LW'(reqAck),      '0);
      chk({tag, ".rspValid"},    LW'(rspValid),    '0);
      chk({tag, ".rspError"},    LW'(rspError),    '0);
      chk({tag, ".rspData"},     rspData,          '0);
      chk({tag, ".memReqValid"}, LW'(memReqValid), '0);
      chk({tag, ".memReqWrite"}, LW'(memReqWrite), '0);
      chk({tag, ".memReqAddr"},  LW'(memReqAddr),  '0);
      chk({tag, ".memReqWdata"}, memReqWdata,      '0);
   endtask

   logic [LW-1:0] pat;
   logic [LW-1:0] exp_data;
   logic [25:0]   exp_addr [3];
   logic [2:0]    exp_oh;
   int            g;

   initial begin
      n_chk       = 0;
      n_err       = 0;
      rstN        = 1'b0;
      reqValid    = '0;
      reqWrite    = '0;
      reqAddr     = '0;
      reqWdata    = '0;
      memReqReady = 1'b0;
      memRspValid = 1'b0;
      memRspData  = '0;

      // Reset state
      cyc();
      cyc();
      #2 chk_all_zero("reset");
      rstN = 1'b1;

      // Single I-cache read at 0x0100040, response at cycle 3
      cyc();
      reqValid   = 3'b001;
      reqWrite   = 3'b000;
      reqAddr[0] = 26'h0100040;
      #2 chk("rd.c0.ack", LW'(reqAck), LW'(3'b001));
      chk("rd.c0.memvalid", LW'(memReqValid), '0);
      cyc();
      reqValid    = '0;
      memReqReady = 1'b1;
      #2 chk("rd.c1.memvalid", LW'(memReqValid), LW'(1'b1));
      chk("rd.c1.addr", LW'(memReqAddr), LW'(26'h0100040));
      chk("rd.c1.write", LW'(memReqWrite), '0);
      chk("rd.c1.ack", LW'(reqAck), '0);
      cyc();
      memReqReady = 1'b0;
      #2 chk("rd.c2.memvalid", LW'(memReqValid), '0);
      chk("rd.c2.rspvalid", LW'(rspValid), '0);
      cyc();
      memRspValid = 1'b1;
      memRspData  = {16{8'hA5}};
      #2 chk("rd.c3.rspvalid", LW'(rspValid), '0);
      cyc();
      memRspValid = 1'b0;
      memRspData  = '0;
      #2 chk("rd.c4.rspvalid", LW'(rspValid), LW'(3'b001));
      chk("rd.c4.data", rspData, {16{8'hA5}});
      chk("rd.c4.err", LW'(rspError), '0);

      // D-cache write to an IO address: immediate error, memory untouched
      cyc();
      reqValid    = 3'b010;
      reqWrite    = 3'b010;
      reqAddr[1]  = 26'h1210000;
      reqWdata[1] = {4{32'h1111_2222}};
      #2 chk("io.c0.ack", LW'(reqAck), LW'(3'b010));
      chk("io.c0.rspvalid", LW'(rspValid), '0);
      cyc();
      reqValid = '0;
      #2 chk("io.c1.rspvalid", LW'(rspValid), LW'(3'b010));
      chk("io.c1.err", LW'(rspError), LW'(1'b1));
      chk("io.c1.data", rspData, '0);
      chk("io.c1.memvalid", LW'(memReqValid), '0);
      cyc();
      #2 chk("io.c2.rspvalid", LW'(rspValid), '0);
      chk("io.c2.memvalid", LW'(memReqValid), '0);

      // Uncachable read that times out after TO WAIT cycles
      reqValid   = 3'b100;
      reqWrite   = 3'b000;
      reqAddr[2] = 26'h2100000;
      #2 chk("to.c0.ack", LW'(reqAck), LW'(3'b100));
      cyc();
      reqValid    = '0;
      memReqReady = 1'b1;
      #2 chk("to.c1.memvalid", LW'(memReqValid), LW'(1'b1));
      chk("to.c1.addr", LW'(memReqAddr), LW'(26'h2100000));
      for (int i = 0; i < TO; i++) begin
         cyc();
         memReqReady = 1'b0;
         #2 chk($sformatf("to.wait%0d.rspvalid", i), LW'(rspValid), '0);
      end
      cyc();
      #2 chk("to.rspvalid", LW'(rspValid), LW'(3'b100));
      chk("to.err", LW'(rspError), LW'(1'b1));
      chk("to.data", rspData, '0);
      cyc();
      memRspValid = 1'b1;
      memRspData  = {LW{1'b1}};
      #2 chk("to.late.rspvalid", LW'(rspValid), '0);
      cyc();
      memRspValid = 1'b0;
      memRspData  = '0;
      reqValid    = 3'b001;
      reqAddr[0]  = 26'h0000208;
      #2 chk("to.next.ack", LW'(reqAck), LW'(3'b001));
      chk("to.next.rspvalid", LW'(rspValid), '0);
      cyc();
      reqValid    = '0;
      memReqReady = 1'b1;
      #2 chk("to.next.addr", LW'(memReqAddr), LW'(26'h0000200));
      chk("to.next.memvalid", LW'(memReqValid), LW'(1'b1));
      cyc();
      memReqReady = 1'b0;
      memRspValid = 1'b1;
      memRspData  = LW'(32'h1234);
      cyc();
      memRspValid = 1'b0;
      memRspData  = '0;
      #2 chk("to.next.rspvalid", LW'(rspValid), LW'(3'b001));
      chk("to.next.data", rspData, LW'(32'h1234));
      chk("to.next.err", LW'(rspError), '0);

      // Ready stalled 5 cycles, response on the final counted WAIT cycle
      cyc();
      reqValid    = 3'b010;
      reqWrite    = 3'b000;
      reqAddr[1]  = 26'h0123457;
      reqWdata[1] = {4{32'hDEAD_BEEF}};
      #2 chk("st.c0.ack", LW'(reqAck), LW'(3'b010));
      for (int i = 1; i <= 6; i++) begin
         cyc();
         reqValid    = '0;
         memReqReady = (i == 6);
         #2 chk($sformatf("st.c%0d.memvalid", i), LW'(memReqValid), LW'(1'b1));
         chk($sformatf("st.c%0d.addr", i), LW'(memReqAddr), LW'(26'h0123450));
         chk($sformatf("st.c%0d.wdata", i), memReqWdata, {4{32'hDEAD_BEEF}});
         chk($sformatf("st.c%0d.write", i), LW'(memReqWrite), '0);
      end
      for (int i = 0; i < TO; i++) begin
         cyc();
         memReqReady = 1'b0;
         memRspValid = (i == TO - 1);
         memRspData  = {8{16'h5A5A}};
         #2 chk($sformatf("st.wait%0d.rspvalid", i), LW'(rspValid), '0);
      end
      cyc();
      memRspValid = 1'b0;
      memRspData  = '0;
      #2 chk("st.rspvalid", LW'(rspValid), LW'(3'b010));
      chk("st.err", LW'(rspError), '0);
      chk("st.data", rspData, {8{16'h5A5A}});

      // Reset pulsed while in WAIT
      cyc();
      reqValid   = 3'b100;
      reqAddr[2] = 26'h2000010;
      #2 chk("rs.c0.ack", LW'(reqAck), LW'(3'b100));
      cyc();
      reqValid    = '0;
      memReqReady = 1'b1;
      cyc();
      memReqReady = 1'b0;
      cyc();
      rstN     = 1'b0;
      reqValid = 3'b111;
      #2 chk_all_zero("rs.async");
      cyc();
      #2 chk_all_zero("rs.held");
      cyc();
      rstN = 1'b1;

      // All requesters continuously valid: rotation restarts at 0
      reqWrite    = 3'b010;
      reqAddr[0]  = 26'h0100040;
      reqAddr[1]  = 26'h0200088;
      reqAddr[2]  = 26'h2000010;
      exp_addr[0] = 26'h0100040;
      exp_addr[1] = 26'h0200080;
      exp_addr[2] = 26'h2000010;
      for (int t = 0; t < 30; t++) begin
         g      = t % 3;
         exp_oh = 3'b001 << g;
         pat    = {4{32'(t) ^ 32'hC0DE_0000}};
         exp_data = (g == 1) ? '0 : pat;
         #2 chk($sformatf("rr%0d.ack", t), LW'(reqAck), LW'(exp_oh));
         cyc();
         memReqReady = 1'b1;
         #2 chk($sformatf("rr%0d.addr", t), LW'(memReqAddr), LW'(exp_addr[g]));
         chk($sformatf("rr%0d.write", t), LW'(memReqWrite), LW'(g == 1));
         cyc();
         memReqReady = 1'b0;
         memRspValid = 1'b1;
         memRspData  = pat;
         cyc();
         memRspValid = 1'b0;
         memRspData  = '0;
         #2 chk($sformatf("rr%0d.rspvalid", t), LW'(rspValid), LW'(exp_oh));
         chk($sformatf("rr%0d.data", t), rspData, exp_data);
         chk($sformatf("rr%0d.err", t), LW'(rspError), '0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
